vx_dvstack_unit: RTL and testbench



---
 rtl/vx_dvstack_unit_pkg.sv | 18 +
 rtl/vx_dvstack_unit_mem.sv | 34 +++
 rtl/vx_dvstack_unit.sv | 141 ++++++++++++++
 tb/tb_vx_dvstack_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vx_dvstack_unit_pkg.sv
// Shared divergence-stack types and sizing. The pointer width SW is also what the
// warp-control unit uses for the stack pointer it returns as the split result.
package vx_dvstack_unit_pkg;

   localparam int NUM_WARPS   = 4;
   localparam int NUM_THREADS = 4;
   localparam int PC_BITS     = 30;
   localparam int NW_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int STACK_DEPTH = 2 * (NUM_THREADS - 1);
   localparam int SW          = $clog2(STACK_DEPTH + 1);

   typedef struct packed {
      logic [NUM_THREADS-1:0] tmask;
      logic [PC_BITS-1:0]     pc;
      logic                   fallthrough;
   } dvstack_entry_t;

endpackage

// File: rtl/vx_dvstack_unit_mem.sv
// Per-warp divergence stack storage: register array indexed {wid, ptr}, asynchronous
// read of one entry and a two-entry write (at ptr and ptr+1) for a push.
module vx_dvstack_unit_mem
   import vx_dvstack_unit_pkg::*;
(
   input  logic           clk,
   input  logic [NW_W-1:0] rd_wid,
   input  logic [SW-1:0]   rd_ptr,
   output dvstack_entry_t  rd_entry,
   input  logic            push_en,
   input  logic [NW_W-1:0] wr_wid,
   input  logic [SW-1:0]   wr_ptr,
   input  dvstack_entry_t  wr_entry0,
   input  dvstack_entry_t  wr_entry1
);

   // Full 2^SW slots per warp so a wrapped pointer still lands on a real register.
   localparam int ENTRIES = NUM_WARPS * (2 ** SW);

   dvstack_entry_t mem_q [ENTRIES];

   logic [SW-1:0] wr_ptr_p1;
   assign wr_ptr_p1 = wr_ptr + SW'(1);

   assign rd_entry = mem_q[{rd_wid, rd_ptr}];

   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[{wr_wid, wr_ptr}]    <= wr_entry0;
         mem_q[{wr_wid, wr_ptr_p1}] <= wr_entry1;
      end
   end

endmodule

// File: rtl/vx_dvstack_unit.sv
// Per-warp IPDOM divergence stack: applies split/join commands as registered tmask/PC
// updates to the scheduler. Optional checking is enabled by defining DV_STACK_CHECK_EN.
module vx_dvstack_unit
   import vx_dvstack_unit_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   split_valid,
   input  logic [NW_W-1:0]        split_wid,
   input  logic                   split_is_dvg,
   input  logic [NUM_THREADS-1:0] split_then_tmask,
   input  logic [NUM_THREADS-1:0] split_else_tmask,
   input  logic [PC_BITS-1:0]     split_next_pc,
   input  logic [NUM_THREADS-1:0] split_cur_tmask,
   input  logic                   join_valid,
   input  logic [NW_W-1:0]        join_wid,
   input  logic [SW-1:0]          join_stack_ptr,
   input  logic [NW_W-1:0]        dvstack_wid,
   output logic [SW-1:0]          dvstack_ptr,
   output logic                   tmask_upd_valid,
   output logic [NW_W-1:0]        tmask_upd_wid,
   output logic [NUM_THREADS-1:0] tmask_upd_mask,
   output logic                   pc_upd_valid,
   output logic [PC_BITS-1:0]     pc_upd_pc,
   output logic                   stack_err
);

`ifdef DV_STACK_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   // Handshake: split_valid/join_valid are single-cycle strobes with no ready; every
   // strobe is consumed in its cycle. tmask_upd_valid (and pc_upd_valid, only together
   // with it) pulse for exactly one cycle and the scheduler cannot stall them.

   logic [SW-1:0]  ptr_q [NUM_WARPS];
   logic [SW-1:0]  split_ptr;
   logic [SW-1:0]  join_cur_ptr;
   logic [SW:0]    split_room;
   logic           split_dvg;
   logic           overflow;
   logic           collide;
   logic           join_pop_req;
   logic           underflow;
   logic           do_push;
   logic           do_pop;
   dvstack_entry_t top_entry;
   dvstack_entry_t push_entry0;
   dvstack_entry_t push_entry1;
   logic           err_q;

   assign split_ptr    = ptr_q[split_wid];
   assign join_cur_ptr = ptr_q[join_wid];
   assign dvstack_ptr  = ptr_q[dvstack_wid];

   assign split_dvg    = split_valid && split_is_dvg;
   assign split_room   = {1'b0, split_ptr} + (SW+1)'(2);
   assign overflow     = CHECK_EN && split_dvg && (split_room > (SW+1)'(STACK_DEPTH));
   assign collide      = CHECK_EN && split_valid && join_valid;
   assign join_pop_req = join_valid && !collide && (join_stack_ptr != join_cur_ptr);
   assign underflow    = CHECK_EN && join_pop_req && (join_cur_ptr == '0);
   assign do_push      = split_dvg && !overflow;
   assign do_pop       = join_pop_req && !underflow;

   // Restore entry below, deferred else-path above it so it pops first.
   assign push_entry0 = '{tmask: split_cur_tmask, pc: split_next_pc, fallthrough: 1'b1};
   assign push_entry1 = '{tmask: split_else_tmask, pc: split_next_pc, fallthrough: 1'b0};

   vx_dvstack_unit_mem u_mem (
      .clk       (clk),
      .rd_wid    (join_wid),
      .rd_ptr    (join_cur_ptr - SW'(1)),
      .rd_entry  (top_entry),
      .push_en   (do_push),
      .wr_wid    (split_wid),
      .wr_ptr    (split_ptr),
      .wr_entry0 (push_entry0),
      .wr_entry1 (push_entry1)
   );

   logic                   nxt_tvalid;
   logic [NW_W-1:0]        nxt_wid;
   logic [NUM_THREADS-1:0] nxt_mask;
   logic                   nxt_pvalid;
   logic [PC_BITS-1:0]     nxt_pc;

   always_comb begin
      nxt_tvalid = 1'b0;
      nxt_wid    = tmask_upd_wid;
      nxt_mask   = tmask_upd_mask;
      nxt_pvalid = 1'b0;
      nxt_pc     = pc_upd_pc;
      if (split_dvg) begin
         // An overflowing split keeps the warp running undiverged on its current mask.
         nxt_tvalid = 1'b1;
         nxt_wid    = split_wid;
         nxt_mask   = overflow ? split_cur_tmask : split_then_tmask;
      end else if (do_pop) begin
         nxt_tvalid = 1'b1;
         nxt_wid    = join_wid;
         nxt_mask   = top_entry.tmask;
         if (!top_entry.fallthrough) begin
            nxt_pvalid = 1'b1;
            nxt_pc     = top_entry.pc;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < NUM_WARPS; w++) ptr_q[w] <= '0;
         tmask_upd_valid <= 1'b0;
         tmask_upd_wid   <= '0;
         tmask_upd_mask  <= '0;
         pc_upd_valid    <= 1'b0;
         pc_upd_pc       <= '0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            if (do_push && (split_wid == NW_W'(w)))
               ptr_q[w] <= split_ptr + SW'(2);
            else if (do_pop && (join_wid == NW_W'(w)))
               ptr_q[w] <= join_cur_ptr - SW'(1);
         end
         tmask_upd_valid <= nxt_tvalid;
         tmask_upd_wid   <= nxt_wid;
         tmask_upd_mask  <= nxt_mask;
         pc_upd_valid    <= nxt_pvalid;
         pc_upd_pc       <= nxt_pc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_q | overflow | underflow | collide;
   end

   assign stack_err = CHECK_EN ? err_q : 1'b0;

endmodule

// File: tb/tb_vx_dvstack_unit.sv
// Directed table-driven bench for vx_dvstack_unit; expectations follow DV_STACK_CHECK_EN.
module tb_vx_dvstack_unit;
   import vx_dvstack_unit_pkg::*;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   split_valid;
   logic [NW_W-1:0]        split_wid;
   logic                   split_is_dvg;
   logic [NUM_THREADS-1:0] split_then_tmask;
   logic [NUM_THREADS-1:0] split_else_tmask;
   logic [PC_BITS-1:0]     split_next_pc;
   logic [NUM_THREADS-1:0] split_cur_tmask;
   logic                   join_valid;
   logic [NW_W-1:0]        join_wid;
   logic [SW-1:0]          join_stack_ptr;
   logic [NW_W-1:0]        dvstack_wid;
   logic [SW-1:0]          dvstack_ptr;
   logic                   tmask_upd_valid;
   logic [NW_W-1:0]        tmask_upd_wid;
   logic [NUM_THREADS-1:0] tmask_upd_mask;
   logic                   pc_upd_valid;
   logic [PC_BITS-1:0]     pc_upd_pc;
   logic                   stack_err;

   vx_dvstack_unit dut (
      .clk              (clk),
      .reset            (reset),
      .split_valid      (split_valid),
      .split_wid        (split_wid),
      .split_is_dvg     (split_is_dvg),
      .split_then_tmask (split_then_tmask),
      .split_else_tmask (split_else_tmask),
      .split_next_pc    (split_next_pc),
      .split_cur_tmask  (split_cur_tmask),
      .join_valid       (join_valid),
      .join_wid         (join_wid),
      .join_stack_ptr   (join_stack_ptr),
      .dvstack_wid      (dvstack_wid),
      .dvstack_ptr      (dvstack_ptr),
      .tmask_upd_valid  (tmask_upd_valid),
      .tmask_upd_wid    (tmask_upd_wid),
      .tmask_upd_mask   (tmask_upd_mask),
      .pc_upd_valid     (pc_upd_valid),
      .pc_upd_pc        (pc_upd_pc),
      .stack_err        (stack_err)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic            sv;
      logic [1:0]      swid;
      logic            dvg;
      logic [3:0]      cur;
      logic [3:0]      thn;
      logic [3:0]      els;
      logic [29:0]     pc;
      logic            jv;
      logic [1:0]      jwid;
      logic [2:0]      jptr;
      logic [1:0]      lwid;
      logic            e_tv;
      logic [1:0]      e_wid;
      logic [3:0]      e_mask;
      logic            e_pv;
      logic [29:0]     e_pc;
      logic [2:0]      e_ptr;
      logic            e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t v_blank(input logic [1:0] lwid, input logic [2:0] e_ptr, input logic e_err);
      vec_t v;
      v = '{sv:0, swid:0, dvg:0, cur:0, thn:0, els:0, pc:0, jv:0, jwid:0, jptr:0,
            lwid:lwid, e_tv:0, e_wid:0, e_mask:0, e_pv:0, e_pc:0, e_ptr:e_ptr, e_err:e_err};
      return v;
   endfunction

   function automatic vec_t v_split(input logic [1:0] wid, input logic dvg, input logic [3:0] cur,
                                    input logic [3:0] thn, input logic [3:0] els, input logic [29:0] pc,
                                    input logic e_tv, input logic [3:0] e_mask, input logic [2:0] e_ptr,
                                    input logic e_err);
      vec_t v;
      v = v_blank(wid, e_ptr, e_err);
      v.sv = 1; v.swid = wid; v.dvg = dvg; v.cur = cur; v.thn = thn; v.els = els; v.pc = pc;
      v.e_tv = e_tv; v.e_wid = wid; v.e_mask = e_mask;
      return v;
   endfunction

   function automatic vec_t v_join(input logic [1:0] wid, input logic [2:0] jptr, input logic e_tv,
                                   input logic [3:0] e_mask, input logic e_pv, input logic [29:0] e_pc,
                                   input logic [2:0] e_ptr, input logic e_err);
      vec_t v;
      v = v_blank(wid, e_ptr, e_err);
      v.jv = 1; v.jwid = wid; v.jptr = jptr;
      v.e_tv = e_tv; v.e_wid = wid; v.e_mask = e_mask; v.e_pv = e_pv; v.e_pc = e_pc;
      return v;
   endfunction

   // driver: one command per cycle, outputs checked 1 time unit after the edge
   task automatic drive(input vec_t v);
      split_valid = v.sv; split_wid = v.swid; split_is_dvg = v.dvg;
      split_cur_tmask = v.cur; split_then_tmask = v.thn; split_else_tmask = v.els;
      split_next_pc = v.pc;
      join_valid = v.jv; join_wid = v.jwid; join_stack_ptr = v.jptr;
      dvstack_wid = v.lwid;
   endtask

   task automatic apply(input vec_t v, input string tag);
      drive(v);
      @(posedge clk); #1;
      chk({tag, " tvalid"}, 32'(tmask_upd_valid), 32'(v.e_tv));
      if (v.e_tv) begin
         chk({tag, " wid"}, 32'(tmask_upd_wid), 32'(v.e_wid));
         chk({tag, " mask"}, 32'(tmask_upd_mask), 32'(v.e_mask));
      end
      chk({tag, " pvalid"}, 32'(pc_upd_valid), 32'(v.e_pv));
      if (v.e_pv) chk({tag, " pc"}, 32'(pc_upd_pc), 32'(v.e_pc));
      chk({tag, " ptr"}, 32'(dvstack_ptr), 32'(v.e_ptr));
      chk({tag, " err"}, 32'(stack_err), 32'(v.e_err));
   endtask

   task automatic do_reset();
      drive(v_blank(2'd0, 3'd0, 1'b0));
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      do_reset();

      chk("reset tvalid", 32'(tmask_upd_valid), 32'd0);
      chk("reset pvalid", 32'(pc_upd_valid), 32'd0);
      chk("reset wid", 32'(tmask_upd_wid), 32'd0);
      chk("reset mask", 32'(tmask_upd_mask), 32'd0);
      chk("reset pc", 32'(pc_upd_pc), 32'd0);
      chk("reset err", 32'(stack_err), 32'd0);

      // basic split/join, non-divergent split, nested splits on warp 3
      vecs.push_back(v_blank(2'd2, 3'd0, 1'b0));
      vecs.push_back(v_split(2'd1, 1, 4'b1111, 4'b0011, 4'b1100, 30'h40, 1, 4'b0011, 3'd2, 0));
      vecs.push_back(v_join(2'd1, 3'd0, 1, 4'b1100, 1, 30'h40, 3'd1, 0));
      vecs.push_back(v_join(2'd1, 3'd0, 1, 4'b1111, 0, 30'h0, 3'd0, 0));
      vecs.push_back(v_blank(2'd1, 3'd0, 1'b0));
      vecs.push_back(v_split(2'd0, 0, 4'b1111, 4'b1111, 4'b0000, 30'h80, 0, 4'b0000, 3'd0, 0));
      vecs.push_back(v_join(2'd0, 3'd0, 0, 4'b0000, 0, 30'h0, 3'd0, 0));
      vecs.push_back(v_split(2'd3, 1, 4'b1111, 4'b0111, 4'b1000, 30'h100, 1, 4'b0111, 3'd2, 0));
      vecs.push_back(v_split(2'd3, 1, 4'b0111, 4'b0011, 4'b0100, 30'h200, 1, 4'b0011, 3'd4, 0));
      vecs.push_back(v_split(2'd3, 1, 4'b0011, 4'b0001, 4'b0010, 30'h300, 1, 4'b0001, 3'd6, 0));
`ifdef DV_STACK_CHECK_EN
      vecs.push_back(v_split(2'd3, 1, 4'b1010, 4'b1000, 4'b0010, 30'h3ff, 1, 4'b1010, 3'd6, 1));
      vecs.push_back(v_join(2'd3, 3'd4, 1, 4'b0010, 1, 30'h300, 3'd5, 1));
`else
      vecs.push_back(v_split(2'd3, 1, 4'b1010, 4'b1000, 4'b0010, 30'h3ff, 1, 4'b1000, 3'd0, 0));
      vecs.push_back(v_join(2'd3, 3'd4, 1, 4'b0010, 1, 30'h3ff, 3'd7, 0));
`endif
      foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

      // interleaved warps 0/1, joins in reverse order, reset mid-sequence
      do_reset();
      begin
         vec_t s0;
         s0 = v_split(2'd0, 1, 4'b1111, 4'b0101, 4'b1010, 30'h10, 1, 4'b0101, 3'd2, 0);
         drive(s0);
         #1 chk("no bypass ptr", 32'(dvstack_ptr), 32'd0);
         @(posedge clk); #1;
         chk("s0 ptr", 32'(dvstack_ptr), 32'd2);
         chk("s0 mask", 32'(tmask_upd_mask), 32'b0101);
      end
      apply(v_split(2'd1, 1, 4'b1111, 4'b0110, 4'b1001, 30'h20, 1, 4'b0110, 3'd2, 0), "s1");
      apply(v_join(2'd1, 3'd0, 1, 4'b1001, 1, 30'h20, 3'd1, 0), "j1a");
      apply(v_join(2'd0, 3'd0, 1, 4'b1010, 1, 30'h10, 3'd1, 0), "j0a");
      apply(v_join(2'd1, 3'd0, 1, 4'b1111, 0, 30'h0, 3'd0, 0), "j1b");
      drive(v_blank(2'd0, 3'd0, 1'b0));
      reset = 1'b1;
      #1;
      chk("mid reset tvalid", 32'(tmask_upd_valid), 32'd0);
      chk("mid reset mask", 32'(tmask_upd_mask), 32'd0);
      chk("mid reset ptr w0", 32'(dvstack_ptr), 32'd0);
      dvstack_wid = 2'd1;
      #1 chk("mid reset ptr w1", 32'(dvstack_ptr), 32'd0);
      @(posedge clk); #1 reset = 1'b0;

`ifdef DV_STACK_CHECK_EN
      // underflow join, then a split colliding with a join
      apply(v_join(2'd2, 3'd1, 0, 4'b0000, 0, 30'h0, 3'd0, 1), "underflow");
      do_reset();
      begin
         vec_t c;
         c = v_split(2'd2, 1, 4'b1111, 4'b0001, 4'b1110, 30'h55, 1, 4'b0001, 3'd2, 1);
         c.jv = 1; c.jwid = 2'd2; c.jptr = 3'd7;
         apply(c, "collide");
      end
      apply(v_blank(2'd2, 3'd2, 1'b1), "sticky");
`endif
      apply(v_blank(2'd0, 3'd0, 1'b0 | stack_err), "idle end");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
